// File: rtl/msx_bus_pkg.sv
// Shared types and constants for the MSX/Z80 bus cycle generator and the
// cartridge-side targets it is used to exercise (CH376 port pair, ROM mapper).
package msx_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_TW   = 3'd3,
        ST_T3   = 3'd4
    } bus_state_t;

    // Encoding is {io, write} so a request can be cast directly.
    typedef enum logic [1:0] {
        MEM_RD = 2'b00,
        MEM_WR = 2'b01,
        IO_RD  = 2'b10,
        IO_WR  = 2'b11
    } cycle_t;

    localparam logic [7:0]  CH376_DATA_PORT = 8'h10;
    localparam logic [7:0]  CH376_CMD_PORT  = 8'h11;
    localparam logic [15:0] MAPPER_BANK0    = 16'h5000;
    localparam logic [15:0] MAPPER_BANK1    = 16'h7000;
    localparam logic [15:0] MAPPER_BANK2    = 16'h9000;
    localparam logic [15:0] MAPPER_BANK3    = 16'hB000;
    localparam logic [7:0]  BUS_IDLE_DATA   = 8'hFF;

    function automatic cycle_t cycle_type(input logic io, input logic write);
        return cycle_t'({io, write});
    endfunction

    function automatic logic cycle_is_io(input cycle_t c);
        return (c == IO_RD) || (c == IO_WR);
    endfunction

    function automatic logic cycle_is_write(input cycle_t c);
        return (c == MEM_WR) || (c == IO_WR);
    endfunction

endpackage

// File: rtl/msx_tstate_timer.sv
// Divides clk into Z80 T-states: counts 0..CLK_PER_T-1 and flags the first
// and last clock of each T-state. Held at zero while the bus is idle.
module msx_tstate_timer #(
    parameter int CLK_PER_T = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic t_first,
    output logic t_last
);

    localparam int CW = $clog2(CLK_PER_T);
    localparam logic [CW-1:0] LAST_TICK = CW'(CLK_PER_T - 1);

    logic [CW-1:0] tick_q;
    logic [CW-1:0] tick_d;

    always_comb begin
        tick_d = tick_q;
        if (clear || (tick_q == LAST_TICK)) begin
            tick_d = '0;
        end else begin
            tick_d = tick_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign t_first = (tick_q == '0);
    assign t_last  = (tick_q == LAST_TICK);

endmodule

// File: rtl/msx_bus_cycle_gen.sv
// Host-side MSX bus initiator: turns one request into a T1/T2/TW*/T3 memory or
// I/O cycle with registered strobes and returns a single-cycle response.
module msx_bus_cycle_gen
    import msx_bus_pkg::*;
#(
    parameter int CLK_PER_T = 4,
    parameter int IO_WAIT   = 1,
    parameter int MAX_WAIT  = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_io,
    input  logic        req_write,
    input  logic        req_slot,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [7:0]  rsp_rdata,
    output logic [15:0] a,
    output logic [7:0]  d_out,
    output logic        d_oe,
    input  logic [7:0]  d_in,
    output logic        iorq_n,
    output logic        mreq_n,
    output logic        rd_n,
    output logic        wr_n,
    output logic        sltsl_n,
    input  logic        wait_n
);

    localparam int TW_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [TW_W-1:0] IO_WAIT_C  = TW_W'(IO_WAIT);
    localparam logic [TW_W-1:0] MAX_WAIT_C = TW_W'(MAX_WAIT);

    bus_state_t      state_q, state_d;
    logic [TW_W-1:0] tw_cnt_q, tw_cnt_d;
    logic            err_q, err_d;
    cycle_t          cyc_q;
    logic            slot_q;

    logic [15:0] a_q;
    logic [7:0]  d_out_q;
    logic        d_oe_q;
    logic        iorq_q, mreq_q, rd_q, wr_q, sltsl_q;
    logic        rsp_valid_q, rsp_err_q;
    logic [7:0]  rsp_rdata_q;

    logic t_first, t_last;
    logic accept, is_io, is_write, need_tw;

    msx_tstate_timer #(
        .CLK_PER_T(CLK_PER_T)
    ) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (state_q == ST_IDLE),
        .t_first(t_first),
        .t_last (t_last)
    );

    // The response cycle itself is not ready, which guarantees an idle gap.
    assign req_ready = (state_q == ST_IDLE) && !rsp_valid_q;
    assign accept    = req_valid && req_ready;
    assign is_io     = cycle_is_io(cyc_q);
    assign is_write  = cycle_is_write(cyc_q);
    assign need_tw   = (is_io && (tw_cnt_q < IO_WAIT_C)) || !wait_n;

    always_comb begin
        state_d  = state_q;
        tw_cnt_d = tw_cnt_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_T1;
                    tw_cnt_d = '0;
                    err_d    = 1'b0;
                end
            end
            ST_T1: begin
                if (t_last) state_d = ST_T2;
            end
            ST_T2, ST_TW: begin
                if (t_last) begin
                    if (!need_tw) begin
                        state_d = ST_T3;
                    end else if (tw_cnt_q == MAX_WAIT_C) begin
                        state_d = ST_T3;
                        err_d   = 1'b1;
                    end else begin
                        state_d  = ST_TW;
                        tw_cnt_d = tw_cnt_q + 1'b1;
                    end
                end
            end
            ST_T3: begin
                if (t_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            tw_cnt_q <= '0;
            err_q    <= 1'b0;
            cyc_q    <= MEM_RD;
            slot_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tw_cnt_q <= tw_cnt_d;
            err_q    <= err_d;
            if (accept) begin
                cyc_q  <= cycle_type(req_io, req_write);
                slot_q <= req_slot;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q         <= '0;
            d_out_q     <= '0;
            d_oe_q      <= 1'b0;
            iorq_q      <= 1'b1;
            mreq_q      <= 1'b1;
            rd_q        <= 1'b1;
            wr_q        <= 1'b1;
            sltsl_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= BUS_IDLE_DATA;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            if (accept) begin
                a_q    <= req_io ? {8'h00, req_addr[7:0]} : req_addr;
                d_oe_q <= req_write;
                if (req_write) d_out_q <= req_wdata;
            end
            if ((state_q == ST_T1) && t_last) begin
                mreq_q  <= is_io;
                iorq_q  <= !is_io;
                rd_q    <= is_write;
                wr_q    <= !is_write;
                sltsl_q <= !(!is_io && slot_q);
            end
            if ((state_q == ST_T3) && t_first) begin
                if (err_q) begin
                    rsp_rdata_q <= BUS_IDLE_DATA;
                end else if (!is_write) begin
                    rsp_rdata_q <= d_in;
                end
            end
            // Strobes, data drive and the response all change on IDLE entry.
            if ((state_q == ST_T3) && t_last) begin
                iorq_q      <= 1'b1;
                mreq_q      <= 1'b1;
                rd_q        <= 1'b1;
                wr_q        <= 1'b1;
                sltsl_q     <= 1'b1;
                d_oe_q      <= 1'b0;
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= err_q;
            end
        end
    end

    assign a         = a_q;
    assign d_out     = d_out_q;
    assign d_oe      = d_oe_q;
    assign iorq_n    = iorq_q;
    assign mreq_n    = mreq_q;
    assign rd_n      = rd_q;
    assign wr_n      = wr_q;
    assign sltsl_n   = sltsl_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
